cbrt: RTL and testbench
=======================

CBRT -- requirements
Module: cbrt

Interface
REQ-001 Parameters SHALL be none; all widths are fixed.
REQ-002 clk_i  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-003 rst_i  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 start_i  input  1  request; sampled only in IDLE.
REQ-005 a_bi  input  8  unsigned operand x.
REQ-006 busy_o  output  1  high while a computation is in progress.
REQ-007 y_bo  output  8  result floor(cbrt(x)), zero-extended; range 0..6.

Function
REQ-008 The FSM SHALL have states IDLE, STEP, MUL_START, MUL_WAIT, CMP.
REQ-009 IDLE with start_i=1 SHALL latch x=a_bi, set y=0 and s=6, raise busy_o on the next edge, and enter STEP.
REQ-010 STEP SHALL set y<=y<<1 and enter MUL_START; it lasts 1 cycle.
REQ-011 MUL_START SHALL launch mul8 with operands y and y+1 and enter MUL_WAIT; it lasts 1 cycle.
REQ-012 MUL_WAIT SHALL last exactly 8 cycles, then capture b=(3*p+1)<<s at 16-bit width, where p is the mul8 product.
REQ-013 CMP (1 cycle), if x>=b, SHALL set x<=x-b and y<=y+1.
REQ-014 CMP SHALL then enter STEP with s<=s-3 when s!=0; when s==0 it SHALL load y_bo with the final y, drop busy_o, and enter IDLE.
REQ-015 Latency SHALL be fixed: busy_o high for exactly 33 cycles (3 iterations x 11), independent of a_bi.
REQ-016 y_bo SHALL hold its last result until the next completion; it SHALL NOT change during busy_o.
REQ-017 start_i while busy_o=1 SHALL be ignored, with no effect on the operation in progress.
REQ-018 start_i held high SHALL restart a computation in the cycle after busy_o falls, because IDLE samples it again.
REQ-019 a_bi changes after the start sample SHALL NOT affect the result.
REQ-020 All comparisons and subtractions SHALL be unsigned; x SHALL never underflow.

Reset
REQ-021 rst_i=0 SHALL immediately force IDLE, busy_o=0, y_bo=0, and clear x, y, s and the mul8 state, including mid-operation.
REQ-022 The first start_i after rst_i deasserts SHALL behave as from power-up.

Configuration
REQ-023 With macro CBRT_REM_EN defined, the block SHALL add output rem_bo (8 bit) = x - y_bo^3, taken from the final x. rem_bo SHALL be loaded together with y_bo, and reset to 0.
REQ-024 Without CBRT_REM_EN, the port SHALL be absent and no remainder logic SHALL be present; all other behaviour SHALL be identical.

Structure
REQ-025 Shared package cbrt_pkg SHALL hold:
- the state enum;
- S_INIT=6, S_STEP=3, MUL_LAT=8;
- width constants X_W=8, B_W=16.
REQ-026 There SHALL be one sub-module, mul8: an 8x8 shift-add multiplier.
- Ports: clk_i, rst_i, start_i, a_bi, b_bi, busy_o, y_bo (16 bit).
- It SHALL be busy for exactly MUL_LAT cycles after start.

Verification
REQ-027 a_bi=0, 1, 7 -> y_bo=0, 1, 1; busy_o high exactly 33 cycles each.
REQ-028 a_bi=8, 26, 27, 64, 125 -> y_bo=2, 2, 3, 4, 5.
REQ-029 a_bi=255 -> y_bo=6; with CBRT_REM_EN, rem_bo=39.
REQ-030 start a_bi=27, then pulse start_i with a_bi=200 at cycle 10 -> y_bo=3, completion still at cycle 33.
REQ-031 start a_bi=125, assert rst_i=0 at cycle 15 -> busy_o=0 and y_bo=0 immediately; a new start with a_bi=64 -> y_bo=4.
REQ-032 Sweep a_bi 0..255 against a floor(cbrt) model; all results SHALL match.

Source files
------------

// File: rtl/cbrt_pkg.sv
// Shared definitions for the cube-root block: FSM states, iteration constants
// and datapath widths.
package cbrt_pkg;

    localparam int unsigned X_W     = 8;   // operand / result width
    localparam int unsigned B_W     = 16;  // trial subtrahend width
    localparam int unsigned S_W     = 3;   // shift amount width
    localparam int unsigned CNT_W   = 4;   // multiplier step counter width
    localparam int unsigned S_INIT  = 6;   // first shift (3 bits per root bit)
    localparam int unsigned S_STEP  = 3;
    localparam int unsigned MUL_LAT = 8;   // shift-add multiplier latency

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        MUL_START,
        MUL_WAIT,
        CMP
    } state_e;

endpackage

// File: rtl/cbrt_mul8.sv
// mul8: 8x8 unsigned shift-add multiplier, one partial product per cycle.
// Ports: clk_i, rst_i (async, active low), start_i (accepted when idle),
//        a_bi/b_bi operands, busy_o (high MUL_LAT cycles), y_bo 16-bit product.
module mul8
    import cbrt_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [X_W-1:0]       a_bi,
    input  logic [X_W-1:0]       b_bi,
    output logic                 busy_o,
    output logic [2*X_W-1:0]     y_bo
);

    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     cnt_q,  cnt_d;
    logic [2*X_W-1:0]     a_q,    a_d;
    logic [X_W-1:0]       b_q,    b_d;
    logic [2*X_W-1:0]     acc_q,  acc_d;

    // Next-state: load operands on start, then add/shift once per cycle.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        if (!busy_q) begin
            if (start_i) begin
                a_d    = (2*X_W)'(a_bi);
                b_d    = b_bi;
                acc_d  = '0;
                cnt_d  = CNT_W'(MUL_LAT);
                busy_d = 1'b1;
            end
        end else begin
            if (b_q[0]) begin
                acc_d = acc_q + a_q;
            end
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
        end
    end

    assign busy_o = busy_q;
    assign y_bo   = acc_q;

endmodule

// File: rtl/cbrt.sv
// cbrt: floor(cube root) of an 8-bit unsigned operand, digit-by-digit with a
// shared shift-add multiplier. Fixed 33-cycle latency.
// Ports: clk_i, rst_i (async, active low), start_i (sampled in IDLE),
//        a_bi operand, busy_o, y_bo result (held until next completion).
// Option: define CBRT_REM_EN to add rem_bo = x - y_bo^3.
module cbrt
    import cbrt_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [X_W-1:0]  a_bi,
    output logic            busy_o,
    output logic [X_W-1:0]  y_bo
`ifdef CBRT_REM_EN
    ,
    output logic [X_W-1:0]  rem_bo
`endif
);

    state_e            state_q, state_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [X_W-1:0]    y_q, y_d;
    logic [S_W-1:0]    s_q, s_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic [X_W-1:0]    res_q, res_d;
`ifdef CBRT_REM_EN
    logic [X_W-1:0]    rem_q, rem_d;
`endif

    logic              mul_start_c;
    logic              mul_busy;
    logic [B_W-1:0]    mul_p;
    logic [B_W-1:0]    b_c;
    logic [X_W-1:0]    x_n, y_n;

    mul8 u_mul8 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (mul_start_c),
        .a_bi    (y_q),
        .b_bi    (y_q + X_W'(1)),
        .busy_o  (mul_busy),
        .y_bo    (mul_p)
    );

    // Trial subtrahend (3*y*(y+1)+1) << s from the settled product.
    assign b_c = (mul_p * B_W'(3) + B_W'(1)) << s_q;

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        s_d         = s_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        res_d       = res_q;
`ifdef CBRT_REM_EN
        rem_d       = rem_q;
`endif
        mul_start_c = 1'b0;
        x_n         = x_q;
        y_n         = y_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    x_d     = a_bi;
                    y_d     = '0;
                    s_d     = S_W'(S_INIT);
                    busy_d  = 1'b1;
                    state_d = STEP;
                end
            end
            STEP: begin
                y_d     = y_q << 1;
                state_d = MUL_START;
            end
            MUL_START: begin
                mul_start_c = 1'b1;
                cnt_d       = CNT_W'(MUL_LAT - 1);
                state_d     = MUL_WAIT;
            end
            MUL_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = CMP;
                end else if (mul_busy) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CMP: begin
                if (B_W'(x_q) >= b_c) begin
                    x_n = x_q - X_W'(b_c);
                    y_n = y_q + X_W'(1);
                end
                x_d = x_n;
                y_d = y_n;
                if (s_q != '0) begin
                    s_d     = s_q - S_W'(S_STEP);
                    state_d = STEP;
                end else begin
                    res_d   = y_n;
`ifdef CBRT_REM_EN
                    rem_d   = x_n;
`endif
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            res_q   <= '0;
`ifdef CBRT_REM_EN
            rem_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            res_q   <= res_d;
`ifdef CBRT_REM_EN
            rem_q   <= rem_d;
`endif
        end
    end

    assign busy_o = busy_q;
    assign y_bo   = res_q;
`ifdef CBRT_REM_EN
    assign rem_bo = rem_q;
`endif

endmodule

// File: tb/tb_cbrt.sv
// Self-checking bench for cbrt: directed cases, a full operand sweep and
// randomized runs, all checked against an integer cube-root model.
module tb_cbrt;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic [7:0] a_bi;
    logic       busy_o;
    logic [7:0] y_bo;
`ifdef CBRT_REM_EN
    logic [7:0] rem_bo;
`endif

    int checks   = 0;
    int failures = 0;

    cbrt dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .a_bi    (a_bi),
        .busy_o  (busy_o),
        .y_bo    (y_bo)
`ifdef CBRT_REM_EN
        ,
        .rem_bo  (rem_bo)
`endif
    );

    always #5 clk_i = ~clk_i;

    function automatic int ref_root(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // mode 0: quiet; 1: random start/a_bi noise while busy; 2: one start pulse (a=200) at cycle 10.
    task automatic run(input logic [7:0] v, input int mode, input bit hold,
                       output int cyc, output int y_seen, output bit stable);
        logic [7:0] prev;
        @(negedge clk_i);
        start_i = 1'b1;
        a_bi    = v;
        @(negedge clk_i);
        start_i = hold;
        a_bi    = 8'($urandom);
        prev    = y_bo;
        stable  = 1'b1;
        cyc     = 0;
        while (busy_o === 1'b1 && cyc < 100) begin
            cyc++;
            if (y_bo !== prev) stable = 1'b0;
            if (mode == 1 && cyc < 30) begin
                start_i = 1'($urandom);
                a_bi    = 8'($urandom);
            end else if (mode == 2) begin
                start_i = (cyc == 10);
                if (cyc == 10) a_bi = 8'd200;
            end else begin
                start_i = hold;
            end
            @(negedge clk_i);
        end
        y_seen = y_bo;
    endtask

    task automatic check_run(input logic [7:0] v, input int mode, input string tag);
        int cyc, y_seen;
        bit stable;
        run(v, mode, 1'b0, cyc, y_seen, stable);
        start_i = 1'b0;
        chk({tag, "_busy_cycles"}, cyc, 33);
        chk({tag, "_y"}, y_seen, ref_root(int'(v)));
        chk({tag, "_y_stable"}, int'(stable), 1);
`ifdef CBRT_REM_EN
        chk({tag, "_rem"}, int'(rem_bo), int'(v) - ref_root(int'(v)) ** 3);
`endif
    endtask

    initial begin
        int cyc, y_seen;
        bit stable;
        int sweep_bad;
        logic [7:0] vals [9];
        vals = '{8'd0, 8'd1, 8'd7, 8'd8, 8'd26, 8'd27, 8'd64, 8'd125, 8'd255};

        rst_i   = 1'b0;
        start_i = 1'b0;
        a_bi    = 8'd0;
        repeat (3) @(negedge clk_i);
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_y", int'(y_bo), 0);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("post_reset_busy", int'(busy_o), 0);

        // Directed operands, including perfect cubes and their neighbours.
        foreach (vals[i]) check_run(vals[i], 0, $sformatf("dir%0d", vals[i]));

        // Ignored start pulse mid-operation with a different operand.
        check_run(8'd27, 2, "start_ignored");

        // Held start restarts one cycle after busy falls.
        run(8'd8, 0, 1'b1, cyc, y_seen, stable);
        chk("hold_first_y", y_seen, 2);
        a_bi = 8'd26;
        @(negedge clk_i);
        chk("hold_restart_busy", int'(busy_o), 1);
        start_i = 1'b0;
        a_bi    = 8'd0;
        cyc     = 1;
        while (busy_o === 1'b1 && cyc < 100) begin
            @(negedge clk_i);
            if (busy_o === 1'b1) cyc++;
        end
        chk("hold_second_cycles", cyc, 33);
        chk("hold_second_y", int'(y_bo), 2);

        // Asynchronous reset mid-operation, then a clean restart.
        check_run(8'd255, 0, "pre_reset");
        @(negedge clk_i);
        start_i = 1'b1;
        a_bi    = 8'd125;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (14) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("midreset_busy", int'(busy_o), 0);
        chk("midreset_y", int'(y_bo), 0);
`ifdef CBRT_REM_EN
        chk("midreset_rem", int'(rem_bo), 0);
`endif
        @(negedge clk_i);
        rst_i = 1'b1;
        check_run(8'd64, 0, "after_reset");

        // Full sweep against the model.
        sweep_bad = 0;
        for (int v = 0; v < 256; v++) begin
            run(8'(v), 0, 1'b0, cyc, y_seen, stable);
            checks++;
            assert (y_seen === ref_root(v) && cyc == 33)
            else begin
                failures++;
                sweep_bad++;
                $error("FAIL sweep a=%0d observed y=%0d cycles=%0d expected y=%0d cycles=33",
                       v, y_seen, cyc, ref_root(v));
            end
        end

        // Randomized operands with noisy start/a_bi while busy.
        for (int k = 0; k < 20; k++) begin
            check_run(8'($urandom), 1, $sformatf("rand%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
